// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// Op codes mirror the decoder's md-class field; cycle counts fit a 5-bit counter.
package mdu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int CNT_W           = 5;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 32x32 multiply / divide producing {hi,lo}; flags divide by zero.
// Works on magnitudes so signed div truncates toward zero and MIN/-1 yields MIN, rem 0.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div0
);

  logic        w_is_div;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [63:0] w_p_mag;
  logic [63:0] w_p;

  assign w_is_div = op_is_div(op);
  assign w_signed = op_is_signed(op);
  assign w_a_neg  = w_signed & a[31];
  assign w_b_neg  = w_signed & b[31];
  assign w_b_zero = (b == 32'd0);

  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude
  assign w_a_mag  = w_a_neg ? (32'd0 - a) : a;
  assign w_b_mag  = w_b_neg ? (32'd0 - b) : b;
  assign w_b_safe = w_b_zero ? 32'd1 : w_b_mag;

  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_q      = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  assign w_p_mag  = {32'd0, w_a_mag} * {32'd0, w_b_mag};
  assign w_p      = (w_a_neg ^ w_b_neg) ? (64'd0 - w_p_mag) : w_p_mag;

  assign result   = w_is_div ? {w_r, w_q} : w_p;
  assign div0     = w_is_div & w_b_zero;

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO register pair with a fixed-latency multiply/divide sequencer for the EX stage.
// busy is high exactly N cycles after start; hi/lo update on the edge busy falls.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hien,
  input  logic        loen,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] LP_MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] LP_DIV_N  = CNT_W'(DIV_CYCLES);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_pend;
  logic             r_pend_div0;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [63:0]      w_result;
  logic             w_div0;

  mdu_calc u_calc (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (w_result),
    .div0   (w_div0)
  );

  // Result is computed at start and held; the counter only models latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pend      <= '0;
      r_pend_div0 <= 1'b0;
      r_busy      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pend      <= w_result;
            r_pend_div0 <= w_div0;
            r_cnt       <= op_is_div(op) ? LP_DIV_N : LP_MULT_N;
            r_busy      <= 1'b1;
            r_state     <= RUN;
          end else begin
            if (hien) r_hi <= a;
            if (loen) r_lo <= a;
          end
        end
        RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
            if (!r_pend_div0) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo: latency, results, mthi/mtlo, priority, reset abort.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hien;
  logic        loen;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  always #5 clk = ~clk;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hien  (hien),
    .loen  (loen),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // Requests while busy are illegal for the hazard unit to produce.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && busy === 1'b1 && (start | hien | loen) === 1'b1) begin
      bad++;
      $display("FAIL assert_req_in_run: start=%b hien=%b loen=%b while busy", start, hien, loen);
    end
  end

  // Caller is at a negedge; start is presented immediately so calls chain back to back.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic le, input logic [31:0] eh, input logic [31:0] el,
                        input int n, input string nm);
    int cnt;
    bit held;
    start = 1'b1; op = o; a = x; b = y; loen = le;
    @(negedge clk);
    start = 1'b0; loen = 1'b0; a = 32'd0; b = 32'd0;
    cnt = 0;
    held = 1'b1;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      @(negedge clk);
    end
    total++;
    if (cnt !== n) begin
      bad++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", nm, cnt, n);
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL %s_hold_while_busy: hi/lo changed before commit, want hi=%h lo=%h", nm, m_hi, m_lo);
    end
    total++;
    if (hi !== eh || lo !== el) begin
      bad++;
      $display("FAIL %s_result: got hi=%h lo=%h want hi=%h lo=%h", nm, hi, lo, eh, el);
    end
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0; hien = 1'b0; loen = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_mult();
    run_op(2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, "mult");
    run_op(2'b01, 32'hFFFFFFFE, 32'd3, 1'b0, 32'h00000002, 32'hFFFFFFFA, 5, "multu");
  endtask

  task automatic test_div();
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg");
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 10, "div_negdivisor");
    run_op(2'b11, 32'd7, 32'd0, 1'b0, 32'h00000001, 32'hFFFFFFFD, 10, "divu_by0");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 10, "div_ovf");
  endtask

  task automatic test_mthi_mtlo();
    hien = 1'b1; a = 32'h12345678;
    @(negedge clk);
    hien = 1'b0; a = 32'd0;
    total++;
    if (hi !== 32'h12345678 || lo !== 32'h80000000) begin
      bad++;
      $display("FAIL mthi: got hi=%h lo=%h want hi=12345678 lo=80000000", hi, lo);
    end
    loen = 1'b1; a = 32'hCAFEF00D;
    @(negedge clk);
    loen = 1'b0; a = 32'd0;
    total++;
    if (hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL mtlo: got hi=%h lo=%h want hi=12345678 lo=cafef00d", hi, lo);
    end
    hien = 1'b1; loen = 1'b1; a = 32'h0BADBEEF;
    @(negedge clk);
    hien = 1'b0; loen = 1'b0; a = 32'd0;
    total++;
    if (hi !== 32'h0BADBEEF || lo !== 32'h0BADBEEF) begin
      bad++;
      $display("FAIL mthi_mtlo_both: got hi=%h lo=%h want 0badbeef 0badbeef", hi, lo);
    end
    m_hi = 32'h0BADBEEF;
    m_lo = 32'h0BADBEEF;
  endtask

  task automatic test_start_priority();
    // mtlo data would be a=5; the operation result is 15
    run_op(2'b01, 32'd5, 32'd3, 1'b1, 32'd0, 32'd15, 5, "start_over_mtlo");
  endtask

  task automatic test_back_to_back();
    run_op(2'b01, 32'h00010000, 32'h00010000, 1'b0, 32'd1, 32'd0, 5, "b2b_multu");
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 10, "b2b_divu");
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd1, 5, "b2b_mult");
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_op: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (6) @(negedge clk);
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_discard: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    run_op(2'b00, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12, 5, "mult_after_reset");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_start_priority();
    test_back_to_back();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
